// File: rtl/gpio_event_capture.sv
// Per-pad synchronise, debounce and edge-detect of gpio_in; enabled edges are
// queued as {pad, level, timestamp} in a FIFO drained over a valid/ready port.
module gpio_event_capture #(
  parameter int NPADS       = 44,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TS_WIDTH    = 16,
  localparam int CntW       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                resetb_l,
  input  logic [NPADS-1:0]    gpio_in,
  input  logic [NPADS-1:0]    rise_en,
  input  logic [NPADS-1:0]    fall_en,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [5:0]          evt_pad,
  output logic                evt_level,
  output logic [TS_WIDTH-1:0] evt_ts,
  output logic [NPADS-1:0]    pin_state,
  output logic [CntW-1:0]     fifo_count,
  output logic                overflow,
  input  logic                overflow_clr
);
  localparam int PtrW = $clog2(FIFO_DEPTH);
  localparam int EntW = 7 + TS_WIDTH;
  localparam int ArmW = $clog2(SYNC_STAGES + 2);
  localparam logic [ArmW-1:0] ArmDone = ArmW'(SYNC_STAGES + 1);
  localparam logic [7:0]      DebLast = 8'(DEB_CYCLES - 1);

  logic [NPADS-1:0]    r_sync [SYNC_STAGES];
  logic [NPADS-1:0]    r_samp, r_pinState, r_pend, r_plev;
  logic [7:0]          r_cnt [NPADS];
  logic [ArmW-1:0]     r_arm;
  logic [TS_WIDTH-1:0] r_ts;
  logic [EntW-1:0]     r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     r_rd, r_wr;
  logic [CntW-1:0]     r_count;
  logic [EntW-1:0]     r_head;
  logic                r_ovf;

  logic                w_armed, w_pop, w_push, w_full, w_pushFound, w_pushLevel, w_ovfSet;
  logic [5:0]          w_pushIdx;
  logic [NPADS-1:0]    w_pinNext, w_flip, w_pendNext, w_plevNext;
  logic [7:0]          w_cntNext [NPADS];
  logic [EntW-1:0]     w_pushData, w_headNext;
  logic [PtrW-1:0]     w_rdNext;
  logic [CntW-1:0]     w_countNext;

  assign w_armed = (r_arm == ArmDone);

  // The extra sample flop after the synchroniser sets the flip at
  // SYNC_STAGES+DEB_CYCLES edges after the input change.
  always_ff @(posedge clk) begin
    if (!resetb_l) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_samp <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_samp <= r_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_pinNext = r_pinState;
    w_flip    = '0;
    for (int i = 0; i < NPADS; i++) begin
      w_cntNext[i] = 8'd0;
      if (!w_armed) begin
        w_pinNext[i] = r_sync[SYNC_STAGES-1][i];
      end else if (r_samp[i] != r_pinState[i]) begin
        if (r_cnt[i] == DebLast) begin
          w_pinNext[i] = r_samp[i];
          w_flip[i]    = 1'b1;
        end else begin
          w_cntNext[i] = r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_pushFound = 1'b0;
    w_pushIdx   = '0;
    w_pushLevel = 1'b0;
    for (int i = NPADS - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_pushFound = 1'b1;
        w_pushIdx   = 6'(i);
        w_pushLevel = r_plev[i];
      end
    end
  end

  assign w_full     = (r_count == CntW'(FIFO_DEPTH));
  assign w_pop      = evt_valid & evt_ready;
  assign w_push     = w_pushFound & (~w_full | w_pop);
  assign w_pushData = {w_pushIdx, w_pushLevel, r_ts};

  // A flip on a pad whose event is leaving this cycle simply re-arms it.
  always_comb begin
    w_pendNext = r_pend;
    w_plevNext = r_plev;
    w_ovfSet   = 1'b0;
    for (int i = 0; i < NPADS; i++) begin
      if (w_push && w_pushIdx == 6'(i)) w_pendNext[i] = 1'b0;
      if (w_flip[i] && (w_pinNext[i] ? rise_en[i] : fall_en[i])) begin
        if (r_pend[i] && !(w_push && w_pushIdx == 6'(i))) w_ovfSet = 1'b1;
        w_pendNext[i] = 1'b1;
        w_plevNext[i] = w_pinNext[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb_l) begin
      r_arm      <= '0;
      r_ts       <= '0;
      r_pinState <= '0;
      r_pend     <= '0;
      r_plev     <= '0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < NPADS; i++) r_cnt[i] <= 8'd0;
    end else begin
      if (!w_armed) r_arm <= r_arm + ArmW'(1);
      r_ts       <= r_ts + TS_WIDTH'(1);
      r_pinState <= w_pinNext;
      r_pend     <= w_pendNext;
      r_plev     <= w_plevNext;
      r_ovf      <= w_ovfSet | (r_ovf & ~overflow_clr);
      for (int i = 0; i < NPADS; i++) r_cnt[i] <= w_cntNext[i];
    end
  end

  // Head register is loaded from the post-edge head slot, bypassing the
  // memory when that slot is the one being written.
  always_comb begin
    w_rdNext    = r_rd + PtrW'(w_pop);
    w_countNext = r_count + CntW'(w_push) - CntW'(w_pop);
    w_headNext  = '0;
    if (w_countNext != '0) begin
      if (w_push && w_rdNext == r_wr) w_headNext = w_pushData;
      else w_headNext = r_mem[w_rdNext];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb_l) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      r_rd    <= w_rdNext;
      r_wr    <= r_wr + PtrW'(w_push);
      r_count <= w_countNext;
      r_head  <= w_headNext;
    end
  end

  always_ff @(posedge clk) begin
    if (resetb_l && w_push) r_mem[r_wr] <= w_pushData;
  end

  assign evt_valid  = (r_count != '0);
  assign evt_pad    = r_head[EntW-1 -: 6];
  assign evt_level  = r_head[TS_WIDTH];
  assign evt_ts     = r_head[TS_WIDTH-1:0];
  assign pin_state  = r_pinState;
  assign fifo_count = r_count;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_gpio_event_capture.sv
// Directed self-checking bench for gpio_event_capture (4-bit timestamp so
// the wrap case is reachable quickly).
module tb_gpio_event_capture;
  localparam int NPads = 44;

  logic              clk = 1'b0;
  logic              resetb_l;
  logic [NPads-1:0]  gpio_in, rise_en, fall_en;
  logic              evt_ready, evt_valid, evt_level, overflow, overflow_clr;
  logic [5:0]        evt_pad;
  logic [3:0]        evt_ts;
  logic [NPads-1:0]  pin_state;
  logic [3:0]        fifo_count;
  logic [3:0]        tsModel;
  int                testsRun = 0;
  int                testsFailed = 0;

  gpio_event_capture #(.NPADS(NPads), .SYNC_STAGES(2), .DEB_CYCLES(4),
                       .FIFO_DEPTH(8), .TS_WIDTH(4)) dut (
    .clk(clk), .resetb_l(resetb_l), .gpio_in(gpio_in), .rise_en(rise_en),
    .fall_en(fall_en), .evt_ready(evt_ready), .evt_valid(evt_valid),
    .evt_pad(evt_pad), .evt_level(evt_level), .evt_ts(evt_ts),
    .pin_state(pin_state), .fifo_count(fifo_count), .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  // Expected free-running timestamp: zero in reset, +1 per edge afterwards.
  always @(posedge clk) begin
    if (!resetb_l) tsModel <= 4'd0;
    else tsModel <= tsModel + 4'd1;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    resetb_l = 1'b0; gpio_in = '1; rise_en = '1; fall_en = '1;
    evt_ready = 1'b0; overflow_clr = 1'b0;
    tick(2);
    testsRun++; if (pin_state !== '0) begin testsFailed++; $display("[TB] FAIL reset_pin: got %h expected 0", pin_state); end
    testsRun++; if (evt_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_outs: got valid=%b count=%0d ovf=%b expected 0/0/0", evt_valid, fifo_count, overflow); end
    testsRun++; if (evt_pad !== 6'd0 || evt_ts !== 4'd0 || evt_level !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_head: got pad=%0d ts=%0d lvl=%b expected 0", evt_pad, evt_ts, evt_level); end
    resetb_l = 1'b1;
    tick(2);
    testsRun++; if (pin_state !== '0) begin testsFailed++; $display("[TB] FAIL arm_pin2: got %h expected 0", pin_state); end
    tick(1);
    testsRun++; if (pin_state !== '1) begin testsFailed++; $display("[TB] FAIL arm_pin3: got %h expected all-ones", pin_state); end
    tick(12);
    testsRun++; if (evt_valid !== 1'b0 || fifo_count !== 4'd0) begin testsFailed++; $display("[TB] FAIL arm_noevt: got valid=%b count=%0d expected 0/0", evt_valid, fifo_count); end
  endtask

  task automatic test_single_edge;
    resetb_l = 1'b0; gpio_in = '0; rise_en = '0; fall_en = '0;
    tick(1);
    resetb_l = 1'b1;
    tick(4);
    testsRun++; if (pin_state !== '0) begin testsFailed++; $display("[TB] FAIL se_pin0: got %h expected 0", pin_state); end
    rise_en[5] = 1'b1; evt_ready = 1'b1; gpio_in[5] = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick(1);
      testsRun++; if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL se_early%0d: got valid=%b expected 0", e, evt_valid); end
    end
    tick(1);
    testsRun++; if (pin_state[5] !== 1'b1 || evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL se_flip: got pin5=%b valid=%b expected 1/0", pin_state[5], evt_valid); end
    tick(1);
    testsRun++; if (evt_valid !== 1'b1 || evt_pad !== 6'd5 || evt_level !== 1'b1 || evt_ts !== tsModel - 4'd1) begin testsFailed++; $display("[TB] FAIL se_event: got v=%b pad=%0d lvl=%b ts=%0d expected 1/5/1/%0d", evt_valid, evt_pad, evt_level, evt_ts, tsModel - 4'd1); end
    tick(1);
    testsRun++; if (evt_valid !== 1'b0 || fifo_count !== 4'd0) begin testsFailed++; $display("[TB] FAIL se_pop: got valid=%b count=%0d expected 0/0", evt_valid, fifo_count); end
  endtask

  task automatic test_glitch;
    int nEv;
    logic pinSeen;
    logic [5:0] evPad [4];
    logic evLev [4];
    rise_en[3] = 1'b1; fall_en[3] = 1'b1; evt_ready = 1'b1;
    nEv = 0; pinSeen = 1'b0;
    gpio_in[3] = 1'b1;
    tick(3);
    gpio_in[3] = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick(1);
      if (evt_valid) nEv++;
      if (pin_state[3]) pinSeen = 1'b1;
    end
    testsRun++; if (nEv != 0 || pinSeen !== 1'b0) begin testsFailed++; $display("[TB] FAIL glitch3: got events=%0d pinHigh=%b expected 0/0", nEv, pinSeen); end
    nEv = 0;
    gpio_in[3] = 1'b1;
    tick(4);
    gpio_in[3] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (evt_valid && nEv < 4) begin evPad[nEv] = evt_pad; evLev[nEv] = evt_level; nEv++; end
    end
    testsRun++; if (nEv != 2) begin testsFailed++; $display("[TB] FAIL glitch4_count: got %0d expected 2", nEv); end
    else begin
      testsRun++; if (evPad[0] !== 6'd3 || evLev[0] !== 1'b1 || evPad[1] !== 6'd3 || evLev[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL glitch4_evts: got %0d/%b %0d/%b expected 3/1 3/0", evPad[0], evLev[0], evPad[1], evLev[1]); end
    end
  endtask

  task automatic test_priority;
    logic [3:0] tExp;
    logic [5:0] padExp [3];
    padExp[0] = 6'd0; padExp[1] = 6'd7; padExp[2] = 6'd43;
    evt_ready = 1'b0;
    rise_en[0] = 1'b1; rise_en[7] = 1'b1; rise_en[43] = 1'b1;
    gpio_in[0] = 1'b1; gpio_in[7] = 1'b1; gpio_in[43] = 1'b1;
    tick(8);
    tExp = tsModel - 4'd1;
    testsRun++; if (evt_valid !== 1'b1 || evt_pad !== 6'd0) begin testsFailed++; $display("[TB] FAIL prio_first: got v=%b pad=%0d expected 1/0", evt_valid, evt_pad); end
    tick(2);
    testsRun++; if (fifo_count !== 4'd3 || evt_pad !== 6'd0) begin testsFailed++; $display("[TB] FAIL prio_hold: got count=%0d pad=%0d expected 3/0", fifo_count, evt_pad); end
    evt_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      testsRun++; if (evt_valid !== 1'b1 || evt_pad !== padExp[j] || evt_level !== 1'b1 || evt_ts !== tExp + 4'(j)) begin testsFailed++; $display("[TB] FAIL prio_ev%0d: got v=%b pad=%0d lvl=%b ts=%0d expected 1/%0d/1/%0d", j, evt_valid, evt_pad, evt_level, evt_ts, padExp[j], tExp + 4'(j)); end
      tick(1);
    end
    testsRun++; if (evt_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL prio_empty: got valid=%b expected 0", evt_valid); end
  endtask

  task automatic test_overflow;
    logic [7:0] expLev;
    evt_ready = 1'b0;
    rise_en[9:0] = 10'h3FF; fall_en[9:0] = 10'h3FF;
    expLev = ~gpio_in[7:0];
    gpio_in[7:0] = expLev;
    tick(16);
    testsRun++; if (fifo_count !== 4'd8 || overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_full: got count=%0d ovf=%b expected 8/0", fifo_count, overflow); end
    gpio_in[9] = 1'b1;
    tick(8);
    testsRun++; if (fifo_count !== 4'd8 || overflow !== 1'b0 || pin_state[9] !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_held: got count=%0d ovf=%b pin9=%b expected 8/0/1", fifo_count, overflow, pin_state[9]); end
    gpio_in[9] = 1'b0;
    tick(8);
    testsRun++; if (overflow !== 1'b1 || fifo_count !== 4'd8) begin testsFailed++; $display("[TB] FAIL ovf_set: got ovf=%b count=%0d expected 1/8", overflow, fifo_count); end
    testsRun++; if (evt_pad !== 6'd0 || evt_level !== expLev[0]) begin testsFailed++; $display("[TB] FAIL ovf_head: got pad=%0d lvl=%b expected 0/%b", evt_pad, evt_level, expLev[0]); end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    testsRun++; if (fifo_count !== 4'd8 || evt_pad !== 6'd1) begin testsFailed++; $display("[TB] FAIL ovf_pushpop: got count=%0d pad=%0d expected 8/1", fifo_count, evt_pad); end
    evt_ready = 1'b1;
    for (int j = 1; j < 8; j++) begin
      testsRun++; if (evt_pad !== 6'(j) || evt_level !== expLev[j]) begin testsFailed++; $display("[TB] FAIL ovf_order%0d: got pad=%0d lvl=%b expected %0d/%b", j, evt_pad, evt_level, j, expLev[j]); end
      tick(1);
    end
    testsRun++; if (evt_valid !== 1'b1 || evt_pad !== 6'd9 || evt_level !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_pad9: got v=%b pad=%0d lvl=%b expected 1/9/0", evt_valid, evt_pad, evt_level); end
    tick(1);
    testsRun++; if (evt_valid !== 1'b0 || overflow !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_sticky: got valid=%b ovf=%b expected 0/1", evt_valid, overflow); end
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    testsRun++; if (overflow !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_wrap;
    int guard;
    evt_ready = 1'b1;
    rise_en[10] = 1'b1; rise_en[11] = 1'b1;
    guard = 0;
    while (tsModel != 4'd8 && guard < 20) begin tick(1); guard++; end
    testsRun++; if (tsModel != 4'd8) begin testsFailed++; $display("[TB] FAIL wrap_align: got ts=%0d expected 8", tsModel); end
    gpio_in[10] = 1'b1; gpio_in[11] = 1'b1;
    tick(8);
    testsRun++; if (evt_valid !== 1'b1 || evt_pad !== 6'd10 || evt_ts !== 4'd15) begin testsFailed++; $display("[TB] FAIL wrap_15: got v=%b pad=%0d ts=%0d expected 1/10/15", evt_valid, evt_pad, evt_ts); end
    tick(1);
    testsRun++; if (evt_valid !== 1'b1 || evt_pad !== 6'd11 || evt_ts !== 4'd0) begin testsFailed++; $display("[TB] FAIL wrap_0: got v=%b pad=%0d ts=%0d expected 1/11/0", evt_valid, evt_pad, evt_ts); end
    tick(1);
  endtask

  task automatic test_midreset;
    evt_ready = 1'b0;
    rise_en[12] = 1'b1; gpio_in[12] = 1'b1;
    tick(10);
    testsRun++; if (fifo_count !== 4'd1) begin testsFailed++; $display("[TB] FAIL mid_queued: got %0d expected 1", fifo_count); end
    resetb_l = 1'b0;
    tick(1);
    testsRun++; if (fifo_count !== 4'd0 || evt_valid !== 1'b0 || pin_state !== '0) begin testsFailed++; $display("[TB] FAIL mid_reset: got count=%0d valid=%b pin=%h expected 0/0/0", fifo_count, evt_valid, pin_state); end
    resetb_l = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_glitch();
    test_priority();
    test_overflow();
    test_wrap();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
